// File: rtl/arith_block_seq.sv
// Multi-cycle WIDTH-bit add/subtract unit. Each RUN cycle processes SLICE bits,
// and a carry register links the slices; results are exchanged via start/ready/valid.
module arith_block_seq #(
    parameter int WIDTH = 128,
    parameter int SLICE = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       opsel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic             illegal_op
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_ILLEGAL = 3'b111;

    logic [1:0]       state;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] acc;

    logic [WIDTH-1:0] beff_d;
    logic             cin_d;
    logic [SLICE-1:0] slice_a;
    logic [SLICE-1:0] slice_b;
    logic [SLICE:0]   slice_sum;
    logic [WIDTH-1:0] acc_next;
    logic             last_slice;
    logic             ovf_d;

    // The operand transform is applied once at acceptance so RUN only ever adds.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        beff_d = '0;
        cin_d  = 1'b0;
        case (opsel)
            3'b000: begin beff_d = b;  cin_d = 1'b0; end
            3'b001: begin beff_d = ~b; cin_d = 1'b0; end
            3'b010: begin beff_d = '0; cin_d = 1'b0; end
            3'b011: begin beff_d = ~b; cin_d = 1'b1; end
            3'b100: begin beff_d = '0; cin_d = 1'b1; end
            3'b101: begin beff_d = '1; cin_d = 1'b0; end
            3'b110: begin beff_d = b;  cin_d = 1'b1; end
            default: begin beff_d = '0; cin_d = 1'b0; end
        endcase
    end

    always_comb begin
        slice_a  = '0;
        slice_b  = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx == IDX_W'(i)) begin
                slice_a = a_q[i*SLICE +: SLICE];
                slice_b = b_q[i*SLICE +: SLICE];
            end
        end
        slice_sum = {1'b0, slice_a} + {1'b0, slice_b} + {{SLICE{1'b0}}, carry_q};
        acc_next  = acc;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx == IDX_W'(i)) begin
                acc_next[i*SLICE +: SLICE] = slice_sum[SLICE-1:0];
            end
        end
    end

    assign last_slice = (idx == IDX_W'(NSLICE - 1));
    assign ovf_d      = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (acc_next[WIDTH-1] != a_q[WIDTH-1]);

    assign ready = (state == S_IDLE);
    assign valid = (state == S_DONE);

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            carry_q    <= 1'b0;
            idx        <= '0;
            acc        <= '0;
            result     <= '0;
            cout       <= 1'b0;
            overflow   <= 1'b0;
            zero       <= 1'b0;
            illegal_op <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= beff_d;
                        op_q    <= opsel;
                        carry_q <= cin_d;
                        idx     <= '0;
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc     <= acc_next;
                    carry_q <= slice_sum[SLICE];
                    idx     <= idx + IDX_W'(1);
                    // Outputs load on the edge into DONE so they are visible with valid.
                    if (last_slice) begin
                        state <= S_DONE;
                        if (op_q == OP_ILLEGAL) begin
                            result     <= '0;
                            cout       <= 1'b0;
                            overflow   <= 1'b0;
                            zero       <= 1'b1;
                            illegal_op <= 1'b1;
                        end else begin
                            result     <= acc_next;
                            cout       <= slice_sum[SLICE];
                            overflow   <= ovf_d;
                            zero       <= (acc_next == '0);
                            illegal_op <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arith_block_seq.sv
// Self-checking bench for arith_block_seq: scoreboard on the sliced instance,
// inline checks on a single-slice instance.
module tb_arith_block_seq;

    localparam int W = 128;

    typedef struct packed {
        logic [W-1:0] result;
        logic         cout;
        logic         ovf;
        logic         zero;
        logic         ill;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;

    logic         start = 1'b0;
    logic [2:0]   opsel = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ready, valid, cout, overflow, zero, illegal_op;
    logic [W-1:0] result;

    logic         start2 = 1'b0;
    logic [2:0]   opsel2 = '0;
    logic [W-1:0] a2 = '0;
    logic [W-1:0] b2 = '0;
    logic         ready2, valid2, cout2, overflow2, zero2, illegal_op2;
    logic [W-1:0] result2;

    int checks = 0;
    int failures = 0;
    int valid_count = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    arith_block_seq #(.WIDTH(W), .SLICE(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opsel(opsel), .a(a), .b(b),
        .ready(ready), .valid(valid), .result(result), .cout(cout),
        .overflow(overflow), .zero(zero), .illegal_op(illegal_op)
    );

    arith_block_seq #(.WIDTH(W), .SLICE(W)) dut_full (
        .clk(clk), .rst_n(rst_n), .start(start2), .opsel(opsel2), .a(a2), .b(b2),
        .ready(ready2), .valid(valid2), .result(result2), .cout(cout2),
        .overflow(overflow2), .zero(zero2), .illegal_op(illegal_op2)
    );

    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t m;
        logic [W-1:0] be;
        logic ci;
        logic [W:0] s;
        be = '0;
        ci = 1'b0;
        case (op)
            3'b000: begin be = bv;  ci = 1'b0; end
            3'b001: begin be = ~bv; ci = 1'b0; end
            3'b010: begin be = '0;  ci = 1'b0; end
            3'b011: begin be = ~bv; ci = 1'b1; end
            3'b100: begin be = '0;  ci = 1'b1; end
            3'b101: begin be = '1;  ci = 1'b0; end
            3'b110: begin be = bv;  ci = 1'b1; end
            default: begin be = '0; ci = 1'b0; end
        endcase
        s = {1'b0, av} + {1'b0, be} + {{W{1'b0}}, ci};
        m.result = s[W-1:0];
        m.cout   = s[W];
        m.ovf    = (av[W-1] == be[W-1]) && (s[W-1] != av[W-1]);
        m.zero   = (s[W-1:0] == '0);
        m.ill    = 1'b0;
        if (op == 3'b111) begin
            m.result = '0;
            m.cout   = 1'b0;
            m.ovf    = 1'b0;
            m.zero   = 1'b1;
            m.ill    = 1'b1;
        end
        return m;
    endfunction

    // Scoreboard monitor: every valid on the sliced instance must match a queued expectation.
    always @(negedge clk) begin
        if (rst_n && valid) begin
            exp_t e;
            valid_count++;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid: valid=1 with empty scoreboard at %0t", $time);
            end else begin
                e = sb.pop_front();
                checks++;
                if (result !== e.result) begin
                    failures++;
                    $display("FAIL result: got %h expected %h", result, e.result);
                end
                checks++;
                if ({cout, overflow, zero, illegal_op} !== {e.cout, e.ovf, e.zero, e.ill}) begin
                    failures++;
                    $display("FAIL flags(cout,ovf,zero,ill): got %b expected %b",
                             {cout, overflow, zero, illegal_op}, {e.cout, e.ovf, e.zero, e.ill});
                end
            end
        end
    end

    // Issues one op, scrambles the inputs after acceptance, and checks ready/latency.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
        int lat;
        lat = 0;
        @(negedge clk);
        start = 1'b1; opsel = op; a = av; b = bv;
        sb.push_back(model(op, av, bv));
        @(negedge clk);
        start = 1'b0;
        opsel = 3'($urandom);
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 1; i <= 20; i++) begin
            if (i > 1) @(negedge clk);
            checks++;
            if (ready !== 1'b0) begin
                failures++;
                $display("FAIL busy_ready: ready=%b at cycle t+%0d expected 0", ready, i);
            end
            if (valid === 1'b1) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (lat != 5) begin
            failures++;
            $display("FAIL latency: valid at t+%0d expected t+5", lat);
        end
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || valid !== 1'b0) begin
            failures++;
            $display("FAIL after_done: ready=%b valid=%b expected 1 0", ready, valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({ready, valid, cout, overflow, zero, illegal_op} !== 6'b100000 || result !== '0) begin
            failures++;
            $display("FAIL reset_state: rdy,vld,c,o,z,i=%b result=%h expected 100000 0",
                     {ready, valid, cout, overflow, zero, illegal_op}, result);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add_latency();
        run_op(3'b000, 128'h0000_0000_FFFF_FFFF, 128'h1);
        checks++;
        if (result !== 128'h1_0000_0000) begin
            failures++;
            $display("FAIL add_const: got %h expected 100000000", result);
        end
    endtask

    task automatic test_subtract();
        run_op(3'b011, 128'h0, 128'h1);
        checks++;
        if (result !== {W{1'b1}} || cout !== 1'b0) begin
            failures++;
            $display("FAIL sub_borrow: result=%h cout=%b expected all-ones 0", result, cout);
        end
        run_op(3'b011, 128'h5, 128'h5);
        checks++;
        if (zero !== 1'b1 || cout !== 1'b1) begin
            failures++;
            $display("FAIL sub_equal: zero=%b cout=%b expected 1 1", zero, cout);
        end
        run_op(3'b001, 128'h10, 128'h3);
    endtask

    task automatic test_inc_dec();
        run_op(3'b100, {1'b0, {(W-1){1'b1}}}, 128'h0);
        checks++;
        if (overflow !== 1'b1 || result !== {1'b1, {(W-1){1'b0}}}) begin
            failures++;
            $display("FAIL inc_ovf: overflow=%b result=%h expected 1 800..0", overflow, result);
        end
        run_op(3'b101, 128'h0, 128'h0);
    endtask

    task automatic test_carry_pass();
        run_op(3'b110, {W{1'b1}}, 128'h0);
        checks++;
        if (result !== '0 || cout !== 1'b1) begin
            failures++;
            $display("FAIL carry_chain: result=%h cout=%b expected 0 1", result, cout);
        end
        run_op(3'b010, 128'h1234, 128'hFFFF);
        run_op(3'b000, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
        run_op(3'b110, {1'b0, {(W-1){1'b1}}}, 128'h0);
    endtask

    task automatic test_illegal_ignored_start();
        int vc0;
        vc0 = valid_count;
        @(negedge clk);
        start = 1'b1; opsel = 3'b111; a = 128'hDEAD; b = 128'hBEEF;
        sb.push_back(model(3'b111, 128'hDEAD, 128'hBEEF));
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; opsel = 3'b000; a = 128'h7; b = 128'h9;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        checks++;
        if (valid_count - vc0 != 1) begin
            failures++;
            $display("FAIL single_valid: saw %0d valids expected 1", valid_count - vc0);
        end
        checks++;
        if (illegal_op !== 1'b1 || result !== '0) begin
            failures++;
            $display("FAIL illegal_held: illegal_op=%b result=%h expected 1 0", illegal_op, result);
        end
    endtask

    task automatic test_reset_mid_run();
        int vc0;
        @(negedge clk);
        start = 1'b1; opsel = 3'b000; a = 128'h55; b = 128'h66;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ready, valid, cout, overflow, zero, illegal_op} !== 6'b100000 || result !== '0) begin
            failures++;
            $display("FAIL reset_abort: rdy,vld,c,o,z,i=%b result=%h expected 100000 0",
                     {ready, valid, cout, overflow, zero, illegal_op}, result);
        end
        vc0 = valid_count;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (valid_count != vc0 || ready !== 1'b1) begin
            failures++;
            $display("FAIL post_reset: valids=%0d ready=%b expected 0 1", valid_count - vc0, ready);
        end
    endtask

    task automatic test_single_slice();
        exp_t e;
        e = model(3'b000, 128'h0000_0000_FFFF_FFFF, 128'h1);
        @(negedge clk);
        start2 = 1'b1; opsel2 = 3'b000; a2 = 128'h0000_0000_FFFF_FFFF; b2 = 128'h1;
        @(negedge clk);
        start2 = 1'b0; a2 = '1; b2 = '1; opsel2 = 3'b111;
        checks++;
        if (valid2 !== 1'b0 || ready2 !== 1'b0) begin
            failures++;
            $display("FAIL full_t1: valid=%b ready=%b expected 0 0", valid2, ready2);
        end
        @(negedge clk);
        checks++;
        if (valid2 !== 1'b1 || result2 !== e.result || result2 !== 128'h1_0000_0000 ||
            {cout2, overflow2, zero2, illegal_op2} !== 4'b0000) begin
            failures++;
            $display("FAIL full_t2: valid=%b result=%h flags=%b expected 1 100000000 0000",
                     valid2, result2, {cout2, overflow2, zero2, illegal_op2});
        end
        @(negedge clk);
        checks++;
        if (valid2 !== 1'b0 || ready2 !== 1'b1) begin
            failures++;
            $display("FAIL full_t3: valid=%b ready=%b expected 0 1", valid2, ready2);
        end
    endtask

    initial begin
        test_reset();
        test_add_latency();
        test_subtract();
        test_inc_dec();
        test_carry_pass();
        test_illegal_ignored_start();
        test_reset_mid_run();
        sb.delete();
        test_single_slice();
        run_op(3'b011, 128'h100, 128'h1);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
